// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int unsigned INSTR_W    = 16;
  localparam int unsigned DEF_ADDR_W = 8;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StIssue   = 3'd1,
    StWait    = 3'd2,
    StCapture = 3'd3,
    StCommit  = 3'd4
  } ifu_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ifu_if.sv
// Control, instruction-memory and IR signals of the fetch unit, bundled as one interface.
interface ifu_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
);
  logic              fetch_req;
  logic              stall;
  logic              branch_en;
  logic [ADDR_W-1:0] branch_addr;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rd_en;
  logic [DATA_W-1:0] imem_rdata;
  logic [DATA_W-1:0] ir_din;
  logic              ir_write_en;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic [15:0]       instr_count;

  modport master (
    input  fetch_req, stall, branch_en, branch_addr, imem_rdata,
    output imem_addr, imem_rd_en, ir_din, ir_write_en, pc, busy, instr_count
  );

  modport slave (
    output fetch_req, stall, branch_en, branch_addr, imem_rdata,
    input  imem_addr, imem_rd_en, ir_din, ir_write_en, pc, busy, instr_count
  );
endinterface

// File: rtl/pc_reg.sv
// Program counter: synchronous reset load, external load, and a wrapping pc+1.
module pc_reg #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1
);

  logic [ADDR_W-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (load) begin
      pc_q <= load_addr;
    end
  end

  assign pc       = pc_q;
  // Modulo 2^ADDR_W by construction: all-ones wraps to zero.
  assign pc_plus1 = pc_q + ADDR_W'(1);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch FSM: issues an imem read at the PC, captures the word and pulses the IR load.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter int unsigned       DATA_W   = INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       MEM_LAT  = 1
) (
  input logic   clk,
  input logic   rst,
  ifu_if.master bus
);

  localparam int unsigned CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

  ifu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  lat_q, lat_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [15:0]       cnt_q, cnt_d;

  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_addr;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus1;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (pc_load),
    .load_addr (pc_load_addr),
    .pc        (pc),
    .pc_plus1  (pc_plus1)
  );

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    pend_d       = pend_q;
    pend_addr_d  = pend_addr_q;
    addr_d       = addr_q;
    ir_d         = ir_q;
    cnt_d        = cnt_q;
    pc_load      = 1'b0;
    pc_load_addr = bus.branch_addr;

    // While a fetch is in flight a redirect is parked; the newest one overwrites older ones.
    if (state_q != StIdle && bus.branch_en) begin
      pend_d      = 1'b1;
      pend_addr_d = bus.branch_addr;
    end

    unique case (state_q)
      StIdle: begin
        pc_load = bus.branch_en;
        if (bus.fetch_req && !bus.stall) begin
          state_d = StIssue;
          addr_d  = bus.branch_en ? bus.branch_addr : pc;
        end
      end
      StIssue: begin
        state_d = StWait;
        lat_d   = CNT_W'(MEM_LAT);
      end
      StWait: begin
        if (lat_q == CNT_W'(1)) begin
          state_d = StCapture;
          ir_d    = bus.imem_rdata;
        end else begin
          lat_d = lat_q - CNT_W'(1);
        end
      end
      StCapture: begin
        state_d = StCommit;
      end
      StCommit: begin
        state_d      = StIdle;
        pc_load      = 1'b1;
        pc_load_addr = bus.branch_en ? bus.branch_addr :
                       pend_q        ? pend_addr_q     : pc_plus1;
        pend_d       = 1'b0;
        cnt_d        = sat_inc16(cnt_q);
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      lat_q       <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      addr_q      <= '0;
      ir_q        <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      addr_q      <= addr_d;
      ir_q        <= ir_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.imem_addr   = addr_q;
  assign bus.imem_rd_en  = (state_q == StIssue);
  assign bus.ir_din      = ir_q;
  assign bus.ir_write_en = (state_q == StCommit);
  assign bus.pc          = pc;
  assign bus.busy        = (state_q != StIdle);
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Drives two fetch units (MEM_LAT 1 and 3) with shared stimulus against a transaction model.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fetch_req = 1'b0;
  logic       stall = 1'b0;
  logic       branch_en = 1'b0;
  logic [7:0] branch_addr = 8'h00;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ifu_if #(.ADDR_W(8), .DATA_W(16)) bus0 ();
  ifu_if #(.ADDR_W(8), .DATA_W(16)) bus1 ();

  instr_fetch_unit #(.ADDR_W(8), .DATA_W(16), .RESET_PC(8'h00), .MEM_LAT(1)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  instr_fetch_unit #(.ADDR_W(8), .DATA_W(16), .RESET_PC(8'h00), .MEM_LAT(3)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // Instruction memory shared by both units; each has its own read pipeline.
  logic [15:0] mem [256];
  logic [15:0] junk = 16'h0BAD;
  bit          mv [2];
  logic [7:0]  ma [2];
  int          mc [2];

  logic        rd   [2];
  logic [7:0]  addr [2];
  logic        we   [2];
  logic [15:0] ir   [2];
  logic [7:0]  pcv  [2];
  logic        busy [2];
  logic [15:0] cnt  [2];

  assign bus0.fetch_req   = fetch_req;
  assign bus0.stall       = stall;
  assign bus0.branch_en   = branch_en;
  assign bus0.branch_addr = branch_addr;
  assign bus1.fetch_req   = fetch_req;
  assign bus1.stall       = stall;
  assign bus1.branch_en   = branch_en;
  assign bus1.branch_addr = branch_addr;
  assign bus0.imem_rdata  = (mv[0] && mc[0] == 0) ? mem[ma[0]] : junk;
  assign bus1.imem_rdata  = (mv[1] && mc[1] == 0) ? mem[ma[1]] : junk;

  assign rd[0]   = bus0.imem_rd_en;   assign rd[1]   = bus1.imem_rd_en;
  assign addr[0] = bus0.imem_addr;    assign addr[1] = bus1.imem_addr;
  assign we[0]   = bus0.ir_write_en;  assign we[1]   = bus1.ir_write_en;
  assign ir[0]   = bus0.ir_din;       assign ir[1]   = bus1.ir_din;
  assign pcv[0]  = bus0.pc;           assign pcv[1]  = bus1.pc;
  assign busy[0] = bus0.busy;         assign busy[1] = bus1.busy;
  assign cnt[0]  = bus0.instr_count;  assign cnt[1]  = bus1.instr_count;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Read data is valid only in the MEM_LAT-th cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    junk <= 16'($urandom);
    for (int d = 0; d < 2; d++) begin
      if (rd[d]) begin
        mv[d] <= 1'b1;
        ma[d] <= addr[d];
        mc[d] <= lat_of(d) - 1;
      end else if (mv[d] && mc[d] > 0) begin
        mc[d] <= mc[d] - 1;
      end else begin
        mv[d] <= 1'b0;
      end
    end
  end

  // Transaction model: k = cycles into the current fetch (0 = idle).
  int          k [2];
  logic [7:0]  m_pc [2];
  logic [7:0]  m_faddr [2];
  bit          m_pend [2];
  logic [7:0]  m_paddr [2];
  logic [15:0] m_ir [2];
  logic [15:0] m_cnt [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int d);
    int lat = lat_of(d);
    if (rst) begin
      k[d] = 0; m_pc[d] = 8'h00; m_pend[d] = 1'b0; m_ir[d] = 16'h0; m_cnt[d] = 16'h0;
    end else if (k[d] == 0) begin
      if (branch_en) m_pc[d] = branch_addr;
      if (fetch_req && !stall) begin
        m_faddr[d] = m_pc[d];
        k[d] = 1;
      end
    end else begin
      if (branch_en) begin
        m_pend[d]  = 1'b1;
        m_paddr[d] = branch_addr;
      end
      if (k[d] == 1 + lat) m_ir[d] = mem[m_faddr[d]];
      if (k[d] == 3 + lat) begin
        m_pc[d]   = m_pend[d] ? m_paddr[d] : m_pc[d] + 8'd1;
        m_pend[d] = 1'b0;
        if (m_cnt[d] != 16'hFFFF) m_cnt[d] = m_cnt[d] + 16'd1;
        k[d] = 0;
      end else begin
        k[d] = k[d] + 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_edge(d);
    #1;
    for (int d = 0; d < 2; d++) begin
      int lat = lat_of(d);
      check($sformatf("busy[%0d]", d), 32'(busy[d]), 32'(k[d] != 0));
      check($sformatf("rd_en[%0d]", d), 32'(rd[d]), 32'(k[d] == 1));
      if (k[d] == 1) check($sformatf("imem_addr[%0d]", d), 32'(addr[d]), 32'(m_faddr[d]));
      check($sformatf("ir_write_en[%0d]", d), 32'(we[d]), 32'(k[d] == 3 + lat));
      check($sformatf("ir_din[%0d]", d), 32'(ir[d]), 32'(m_ir[d]));
      check($sformatf("pc[%0d]", d), 32'(pcv[d]), 32'(m_pc[d]));
      check($sformatf("instr_count[%0d]", d), 32'(cnt[d]), 32'(m_cnt[d]));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (k[0] != 0 || k[1] != 0); i++) step();
    check("drain_idle0", 32'(busy[0]), 32'd0);
    check("drain_idle1", 32'(busy[1]), 32'd0);
  endtask

  task automatic jump_to(input logic [7:0] a);
    branch_en = 1'b1; branch_addr = a;
    step();
    branch_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int p [3];
    logic [15:0] w [3];
    int npulse, nissue, t_rd, t_we;
    bit any;

    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0101);
    for (int d = 0; d < 2; d++) begin
      k[d] = 0; m_pc[d] = 8'h00; m_pend[d] = 1'b0; m_paddr[d] = 8'h00;
      m_faddr[d] = 8'h00; m_ir[d] = 16'h0; m_cnt[d] = 16'h0;
    end

    // Reset state
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("reset_pc", 32'(pcv[0]), 32'h00);
    check("reset_busy", 32'(busy[0]), 32'd0);
    check("reset_count", 32'(cnt[0]), 32'd0);
    check("reset_ir", 32'(ir[0]), 32'd0);

    // Single fetch, MEM_LAT=1 timing
    mem[0] = 16'h1234;
    fetch_req = 1'b1; step(); fetch_req = 1'b0;
    check("t1_rd_c1", 32'(rd[0]), 32'd1);
    check("t1_addr_c1", 32'(addr[0]), 32'h00);
    step();
    check("t1_rd_c2", 32'(rd[0]), 32'd0);
    step();
    check("t1_ir_c3", 32'(ir[0]), 32'h1234);
    check("t1_we_c3", 32'(we[0]), 32'd0);
    step();
    check("t1_we_c4", 32'(we[0]), 32'd1);
    step();
    check("t1_we_c5", 32'(we[0]), 32'd0);
    check("t1_pc", 32'(pcv[0]), 32'h01);
    check("t1_count", 32'(cnt[0]), 32'd1);
    drain();

    // Back-to-back with fetch_req held high
    mem[0] = 16'hA1B2; mem[1] = 16'hC3D4; mem[2] = 16'hE5F6;
    jump_to(8'h00);
    p = '{-1, -1, -1}; w = '{16'h0, 16'h0, 16'h0};
    npulse = 0; nissue = 0;
    fetch_req = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      step();
      if (rd[0]) nissue++;
      if (we[0]) begin
        if (npulse < 3) begin p[npulse] = c; w[npulse] = ir[0]; end
        npulse++;
      end
    end
    fetch_req = 1'b0;
    check("t2_pulses", 32'(npulse), 32'd3);
    check("t2_issues", 32'(nissue), 32'd3);
    check("t2_gap01", 32'(p[1] - p[0]), 32'd5);
    check("t2_gap12", 32'(p[2] - p[1]), 32'd5);
    check("t2_w0", 32'(w[0]), 32'hA1B2);
    check("t2_w1", 32'(w[1]), 32'hC3D4);
    check("t2_w2", 32'(w[2]), 32'hE5F6);
    drain();
    check("t2_pc0", 32'(pcv[0]), 32'h03);
    check("t2_pc1", 32'(pcv[1]), 32'h03);

    // Branch during WAIT: in-flight word still delivered, then redirect
    mem[5] = 16'h5A5A; mem[8'h40] = 16'h4040;
    jump_to(8'h05);
    fetch_req = 1'b1; step(); fetch_req = 1'b0;
    step();
    branch_en = 1'b1; branch_addr = 8'h40; step(); branch_en = 1'b0;
    step();
    check("t3_we_c4", 32'(we[0]), 32'd1);
    check("t3_ir", 32'(ir[0]), 32'h5A5A);
    step();
    check("t3_pc", 32'(pcv[0]), 32'h40);
    drain();
    fetch_req = 1'b1; step(); fetch_req = 1'b0;
    check("t3_rd2", 32'(rd[0]), 32'd1);
    check("t3_addr2", 32'(addr[0]), 32'h40);
    drain();
    check("t3_ir2", 32'(ir[0]), 32'h4040);

    // PC wrap at 0xFF, and ISSUE->COMMIT spacing with MEM_LAT=3
    mem[8'hFF] = 16'hBEEF;
    jump_to(8'hFF);
    t_rd = -1; t_we = -1;
    fetch_req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      fetch_req = 1'b0;
      if (rd[1] && t_rd < 0) t_rd = c;
      if (we[1] && t_we < 0) t_we = c;
    end
    check("t4_spacing", 32'(t_we - t_rd), 32'd5);
    check("t4_wrap0", 32'(pcv[0]), 32'h00);
    check("t4_wrap1", 32'(pcv[1]), 32'h00);
    check("t4_ir1", 32'(ir[1]), 32'hBEEF);

    // Reset in WAIT discards the fetch and any late read data
    jump_to(8'h22);
    fetch_req = 1'b1; step(); fetch_req = 1'b0;
    step();
    rst = 1'b1; step(); rst = 1'b0;
    check("t5_busy0", 32'(busy[0]), 32'd0);
    check("t5_busy1", 32'(busy[1]), 32'd0);
    check("t5_pc", 32'(pcv[0]), 32'h00);
    any = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      any |= we[0] | we[1];
    end
    check("t5_no_pulse", 32'(any), 32'd0);
    check("t5_ir0", 32'(ir[0]), 32'h0);
    check("t5_ir1", 32'(ir[1]), 32'h0);

    // Stall blocks acceptance but not an accepted fetch
    any = 1'b0;
    stall = 1'b1; fetch_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      any |= rd[0] | rd[1];
    end
    check("t6_no_issue", 32'(any), 32'd0);
    stall = 1'b0; step();
    stall = 1'b1; fetch_req = 1'b0;
    drain();
    check("t6_count0", 32'(cnt[0]), 32'd1);
    check("t6_count1", 32'(cnt[1]), 32'd1);
    stall = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 600; i++) begin
      fetch_req   = ($urandom_range(1, 0) == 1);
      stall       = ($urandom_range(3, 0) == 0);
      branch_en   = ($urandom_range(6, 0) == 0);
      branch_addr = 8'($urandom);
      rst         = ($urandom_range(63, 0) == 0);
      step();
    end
    fetch_req = 1'b0; stall = 1'b0; branch_en = 1'b0; rst = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
